alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter that shares one combinational ALU between two requesters, e.g. the integer pipeline and a microcoded helper unit. Each requester issues operand/opcode transactions over a valid/ready handshake. The arbiter registers the winning request and drives the shared ALU's srcA/srcB/ALU_control inputs. It captures ALU_result/Zero_flag and returns them with a requester ID over a valid/ready response channel.

## Interface
- WIDTH, 32, operand/result width; must match the shared ALU.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_ready / req1_ready  out  1  port 0 / 1 request accepted this cycle when valid is also high.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands per port.
- req0_op / req1_op  in  3  ALU opcode per port: 000 add, 001 sub, 010 and, 011 or, 101 slt; others yield result 0.
- alu_srcA, alu_srcB  out  WIDTH  to the shared ALU.
- alu_ctrl  out  3  to the shared ALU's ALU_control.
- alu_result  in  WIDTH  from the shared ALU.
- alu_zero  in  1  from the shared ALU's Zero_flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_zero  out  1  captured zero flag.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- IDLE:
  - req*_ready is asserted combinationally only for the granted port. At most one ready is high.
  - Grant goes to the only valid port. If both are valid, grant goes to the port not served last (last_id).
  - On handshake, latch a, b, op and id into operand registers, update last_id to the winner, and go to EXEC.
- EXEC: alu_srcA/alu_srcB/alu_ctrl come from the operand registers. At the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_id, then go to RESP.
- RESP:
  - rsp_valid=1. rsp_result, rsp_zero and rsp_id are held stable until rsp_valid&rsp_ready.
  - On that handshake go to IDLE. No new request is accepted in the same cycle.
- Outside EXEC, the ALU inputs hold the last operand register values. The ALU is combinational, so these values have no effect outside EXEC.
- All req*_ready outputs are 0 in EXEC and RESP. Only one transaction is outstanding at a time.
- A requester may drop valid before its handshake. Arbitration re-evaluates every IDLE cycle, and nothing is latched without a handshake.
- Reset values:
  - state=IDLE, last_id=1 (port 0 wins the first tie).
  - Operand registers 0, alu_ctrl=000.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
- Reset asserted mid-transaction aborts it immediately. The response is lost and no rsp_valid is produced after reset release.
- Width rule: results are the ALU's WIDTH bits unmodified, and add/sub wrap modulo 2^WIDTH.

## Timing
- Request handshake in cycle t drives the ALU during cycle t+1.
- rsp_valid rises at the start of cycle t+2. Minimum latency is 2 cycles.
- With rsp_ready held at 1:
  - The response handshake completes in t+2, IDLE is reached in t+3, and the next accept happens in t+3.
  - Peak throughput is 1 op per 3 cycles.
- Backpressure: each extra rsp_ready=0 cycle adds one RESP cycle. Outputs stay constant during those cycles.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…. The starvation bound for each port is one transaction.
- Only registered state feeds the ALU inputs. The grant/ready path is combinational from req*_valid and last_id.

## Test plan
- Reset: hold rst_n=0 with random inputs. Every output must match its reset value. Release rst_n, then drive req0 with a=5, b=3, op=000: req0_ready=1, then 2 cycles later rsp_valid=1, rsp_result=8, rsp_zero=0, rsp_id=0.
- Opcode sweep on port 1 with a=7, b=7 (result, zero in each case):
  - sub → 0, 1
  - and → 7, 0
  - or → 7, 0
  - slt → 0, 1
  - op=111 → 0, 1
  - a=2, b=9, slt → 1, 0
  - a=0xFFFFFFFF, b=1, add → 0, 1
- Contention: both ports valid continuously for 6 transactions. Grant order must be 0,1,0,1,0,1, with exactly one ready high per IDLE cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_result, rsp_zero and rsp_id stay stable, both readys stay 0, and a single response is delivered when rsp_ready rises.
- Mid-operation reset: assert rst_n=0 during EXEC. Outputs return to reset values asynchronously, before the next clock edge. After release, no stale rsp_valid appears, and port 0 wins the first tie.
- Valid withdrawal: pulse req1_valid for one cycle while the FSM is in RESP, then drop it. No transaction from port 1 is accepted and no extra response is produced.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One transaction in flight: IDLE accepts, EXEC drives the ALU, RESP holds the result.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic             id;
    } req_t;

    state_t           state_q, state_d;
    logic             last_id_q;
    req_t             opnd_q;
    logic             gnt0, gnt1, accept;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q, rsp_id_q;

    // On a tie the port not served last wins; a lone valid port always wins.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid ||  last_id_q);
        gnt1 = req1_valid && (!req0_valid || !last_id_q);
    end

    assign req0_ready = (state_q == IDLE) && gnt0;
    assign req1_ready = (state_q == IDLE) && gnt1;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_id_q    <= 1'b1;
            opnd_q       <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && accept) begin
                last_id_q <= req1_ready;
                opnd_q    <= req1_ready ? req_t'{req1_a, req1_b, req1_op, 1'b1}
                                        : req_t'{req0_a, req0_b, req0_op, 1'b0};
            end
            if (state_q == EXEC) begin
                rsp_result_q <= alu_result;
                rsp_zero_q   <= alu_zero;
                rsp_id_q     <= opnd_q.id;
            end
        end
    end

    // ALU inputs come only from registers; they are don't-care outside EXEC.
    assign alu_srcA   = opnd_q.a;
    assign alu_srcB   = opnd_q.b;
    assign alu_ctrl   = opnd_q.op;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the shared ALU is modelled here behaviourally.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk, rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] alu_srcA, alu_srcB, alu_result;
    logic [2:0]   alu_ctrl;
    logic         alu_zero;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [W-1:0] rsp_result;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_srcA + alu_srcB;
            3'b001:  alu_result = alu_srcA - alu_srcB;
            3'b010:  alu_result = alu_srcA & alu_srcB;
            3'b011:  alu_result = alu_srcA | alu_srcB;
            3'b101:  alu_result = ($signed(alu_srcA) < $signed(alu_srcB)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom);
        rsp_ready = 1'($urandom);
        #3;
        checks++;
        if (rsp_valid !== 0 || rsp_id !== 0 || rsp_result !== 0 || rsp_zero !== 0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b id=%b result=%h zero=%b, required 0 0 0 0",
                     rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        checks++;
        if (alu_srcA !== 0 || alu_srcB !== 0 || alu_ctrl !== 0 || req0_ready !== 0 || req1_ready !== 0) begin
            errors++;
            $display("FAIL reset_alu: srcA=%h srcB=%h ctrl=%b rdy=%b%b, required all 0",
                     alu_srcA, alu_srcB, alu_ctrl, req0_ready, req1_ready);
        end
        step(); step();
        rst_n = 1; rsp_ready = 1;
        idle_inputs();
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 3'b000;
        #1;
        checks++;
        if (req0_ready !== 1 || req1_ready !== 0) begin
            errors++;
            $display("FAIL first_ready: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 0;
        checks++;
        if (rsp_valid !== 0) begin
            errors++;
            $display("FAIL first_exec_valid: rsp_valid=%b, required 0", rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 1 || rsp_result !== 8 || rsp_zero !== 0 || rsp_id !== 0) begin
            errors++;
            $display("FAIL first_rsp: valid=%b result=%0d zero=%b id=%b, required 1 8 0 0",
                     rsp_valid, rsp_result, rsp_zero, rsp_id);
        end
        step();
    endtask

    task automatic test_opcodes();
        logic [W-1:0] ta [7] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF};
        logic [W-1:0] tb [7] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd9, 32'd1};
        logic [2:0]   top [7] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b111, 3'b101, 3'b000};
        logic [W-1:0] tres [7] = '{32'd0, 32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'd0};
        logic         tz [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            req1_valid = 1; req1_a = ta[i]; req1_b = tb[i]; req1_op = top[i];
            #1;
            checks++;
            if (req1_ready !== 1 || req0_ready !== 0) begin
                errors++;
                $display("FAIL op%0d_ready: rdy1=%b rdy0=%b, required 1 0", i, req1_ready, req0_ready);
            end
            step();
            req1_valid = 0;
            checks++;
            if (alu_srcA !== ta[i] || alu_srcB !== tb[i] || alu_ctrl !== top[i]) begin
                errors++;
                $display("FAIL op%0d_alu_in: srcA=%h srcB=%h ctrl=%b, required %h %h %b",
                         i, alu_srcA, alu_srcB, alu_ctrl, ta[i], tb[i], top[i]);
            end
            step();
            checks++;
            if (rsp_valid !== 1 || rsp_result !== tres[i] || rsp_zero !== tz[i] || rsp_id !== 1) begin
                errors++;
                $display("FAIL op%0d_rsp: valid=%b result=%h zero=%b id=%b, required 1 %h %b 1",
                         i, rsp_valid, rsp_result, rsp_zero, rsp_id, tres[i], tz[i]);
            end
            step();
        end
    endtask

    task automatic test_contention();
        rst_n = 0; #2; rst_n = 1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            req0_a = i; req0_b = 1; req0_op = 3'b000;
            req1_a = 10; req1_b = i; req1_op = 3'b001;
            #1;
            checks++;
            if ((req0_ready ^ req1_ready) !== 1 || req1_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL cont%0d_grant: rdy0=%b rdy1=%b, required grant to port %0d",
                         i, req0_ready, req1_ready, i % 2);
            end
            step();
            checks++;
            if (req0_ready !== 0 || req1_ready !== 0) begin
                errors++;
                $display("FAIL cont%0d_exec_ready: rdy0=%b rdy1=%b, required 0 0", i, req0_ready, req1_ready);
            end
            step();
            checks++;
            if (rsp_valid !== 1 || rsp_id !== 1'(i % 2) ||
                rsp_result !== ((i % 2 == 0) ? 32'(i + 1) : 32'(10 - i))) begin
                errors++;
                $display("FAIL cont%0d_rsp: valid=%b id=%b result=%0d, required 1 %0d %0d",
                         i, rsp_valid, rsp_id, rsp_result, i % 2, (i % 2 == 0) ? i + 1 : 10 - i);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int extra;
        rsp_ready = 0;
        req0_valid = 1; req0_a = 20; req0_b = 22; req0_op = 3'b000;
        step();
        req0_valid = 0;
        step();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1 || rsp_result !== 42 || rsp_zero !== 0 || rsp_id !== 0 ||
                req0_ready !== 0 || req1_ready !== 0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b result=%0d zero=%b id=%b rdy=%b%b, required 1 42 0 0 rdy 00",
                         i, rsp_valid, rsp_result, rsp_zero, rsp_id, req0_ready, req1_ready);
            end
            step();
        end
        idle_inputs();
        rsp_ready = 1;
        step();
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid === 1) extra++;
            step();
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL bp_single: extra response cycles=%0d, required 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 3'b011;
        step();
        idle_inputs();
        checks++;
        if (alu_ctrl !== 3'b011) begin
            errors++;
            $display("FAIL mr_exec: ctrl=%b, required 011", alu_ctrl);
        end
        rst_n = 0;
        #1;
        checks++;
        if (rsp_valid !== 0 || rsp_result !== 0 || rsp_id !== 0 || alu_srcA !== 0 ||
            alu_srcB !== 0 || alu_ctrl !== 0) begin
            errors++;
            $display("FAIL mr_async: valid=%b result=%h id=%b srcA=%h srcB=%h ctrl=%b, required all 0",
                     rsp_valid, rsp_result, rsp_id, alu_srcA, alu_srcB, alu_ctrl);
        end
        step();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid !== 0) begin
                errors++;
                $display("FAIL mr_stale%0d: rsp_valid=%b, required 0", i, rsp_valid);
            end
            step();
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if (req0_ready !== 1 || req1_ready !== 0) begin
            errors++;
            $display("FAIL mr_tie: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
        end
        step();
        idle_inputs();
        step(); step();
    endtask

    task automatic test_withdraw();
        int extra;
        rsp_ready = 0;
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 3'b010;
        step();
        req0_valid = 0;
        step();
        req1_valid = 1; req1_a = 9; req1_b = 9; req1_op = 3'b000;
        #1;
        checks++;
        if (req1_ready !== 0 || rsp_valid !== 1 || rsp_result !== 1) begin
            errors++;
            $display("FAIL wd_pulse: rdy1=%b valid=%b result=%0d, required 0 1 1",
                     req1_ready, rsp_valid, rsp_result);
        end
        step();
        req1_valid = 0;
        rsp_ready = 1;
        step();
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid === 1 || req1_ready === 1 || alu_ctrl !== 3'b010) extra++;
            step();
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL wd_no_accept: bad cycles=%0d, required 0", extra);
        end
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout: simulation exceeded time budget");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_opcodes();
        test_contention();
        test_backpressure();
        test_mid_reset();
        test_withdraw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
